button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Converts the raw DE0-CV KEY inputs into clean single-cycle events that a clocked control state machine can consume.
- The KEY inputs are active-low, asynchronous and bouncing.
- Per button, the block provides: a 2-FF synchroniser, a debouncer, press/release pulses, and auto-repeat pulses while held.
- Placement: sits directly upstream of the mode state machine. Its out_event pulses replace using button edges as clocks.

Parameters:
- NUM_BUTTONS, 4: number of KEY inputs conditioned.
- DEBOUNCE_CYCLES, 20'd500_000: consecutive stable cycles required before the debounced level changes (10 ms at 50 MHz). Legal range 2..2^20.
- REPEAT_DELAY, 26'd25_000_000: held cycles from press pulse to first repeat pulse (0.5 s). Must be >= 2.
- REPEAT_PERIOD, 26'd5_000_000: cycles between subsequent repeat pulses (0.1 s). Must be >= 2.
- REPEAT_MASK, 4'b0110: bit i = 1 enables auto-repeat on button i.

Ports:
- in_clk, input, 1: system clock, 50 MHz, rising edge.
- in_reset_n, input, 1: asynchronous, active-low reset.
- in_button, input, NUM_BUTTONS: raw KEY pins, active-low (0 = pressed), asynchronous.
- out_level, output, NUM_BUTTONS: debounced level, active-high (1 = pressed).
- out_press, output, NUM_BUTTONS: 1-cycle pulse when out_level rises.
- out_release, output, NUM_BUTTONS: 1-cycle pulse when out_level falls.
- out_repeat, output, NUM_BUTTONS: 1-cycle auto-repeat pulse.
- out_event, output, NUM_BUTTONS: out_press | out_repeat (combinational OR of registered signals).

Behaviour:
- Reset:
  - All outputs, counters and repeat-phase flags go to 0 asynchronously while in_reset_n = 0.
  - Synchroniser flops reset to 1 (released).
- Synchroniser: 2 flops per bit. pressed_raw[i] = ~sync2[i].
- Debounce, per button, on each rising edge:
  - If pressed_raw == out_level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: out_level <= pressed_raw, cnt <= 0.
  - Else: cnt <= cnt + 1.
- Debounce latency: a pin change arriving after edge T gives out_level changing after edge T+2+DEBOUNCE_CYCLES.
- Glitches: any glitch or bounce shorter than DEBOUNCE_CYCLES stable cycles is ignored, and the counter restarts on every reversal.
- Press/release pulses:
  - out_press / out_release are registered and asserted in exactly the cycle in which out_level first shows its new value.
  - They are never asserted together for the same button.
- Auto-repeat FSM, per button with REPEAT_MASK[i] = 1:
  - States: IDLE, DELAY, PERIOD. 26-bit counter rcnt.
  - IDLE: entered while out_level = 0, rcnt = 0. Goes to DELAY in the cycle out_level rises.
  - DELAY: rcnt increments each cycle. At rcnt == REPEAT_DELAY-1: out_repeat pulse, rcnt <= 0, go to PERIOD.
  - PERIOD: at rcnt == REPEAT_PERIOD-1: out_repeat pulse, rcnt <= 0.
  - Result: first repeat REPEAT_DELAY cycles after the press pulse, then one every REPEAT_PERIOD cycles.
  - Release (out_level falls) returns to IDLE from any state in that same cycle. No repeat pulse in or after the release cycle.
  - Buttons with REPEAT_MASK[i] = 0: out_repeat[i] is tied 0 and the FSM/counter is not generated.
- Independence: buttons are fully independent. Simultaneous presses or releases on different buttons produce pulses in the same cycle.
- Reset mid-operation:
  - All state is cleared.
  - A button still held when reset deasserts is treated as a new press: press pulse after 2+DEBOUNCE_CYCLES cycles, then the normal repeat schedule.
- Widths: counters never wrap; compare-and-clear only. out_level is never X after reset.

Test Plan (sim overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
1. Reset:
   - in_reset_n=0, in_button=4'hF → all outputs 0 immediately.
   - Release reset, idle 20 cycles → all outputs stay 0.
2. Clean press/release:
   - in_button[2] drops after edge T → out_level[2]=1, and out_press[2]=out_event[2]=1 for exactly one cycle, after edge T+6.
   - Raise after edge U → out_release[2] pulse after edge U+6.
3. Bounce:
   - in_button[1] toggles every 2 cycles for 12 cycles, then holds low → no outputs during bounce.
   - Exactly one out_press[1], 6 cycles after the final edge.
   - A 3-cycle low glitch on button 3 → no output.
4. Auto-repeat:
   - Hold button 2 with press pulse at P → out_repeat[2] and out_event[2] at P+10, P+13, P+16.
   - Button 0 held identically → no out_repeat[0].
   - Release → one out_release[2]; no further repeats.
5. Reset mid-hold:
   - Button 1 held with out_level[1]=1; pulse in_reset_n low → outputs 0 asynchronously.
   - Deassert while still held → out_press[1] six cycles later; first repeat 10 cycles after that.
6. Simultaneous:
   - Buttons 1 and 2 drop on the same cycle → identical-cycle out_press[1] and out_press[2].
   - Repeat pulses also coincide.

Source files
------------

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Turns raw active-low bouncing KEY pins into clean debounced
//            levels plus single-cycle press, release and auto-repeat events.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int unsigned                 NUM_BUTTONS     = 4,
  parameter int unsigned                 DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned                 REPEAT_DELAY    = 25_000_000,
  parameter int unsigned                 REPEAT_PERIOD   = 5_000_000,
  parameter logic [NUM_BUTTONS-1:0]      REPEAT_MASK     = 4'b0110
) (
  input  logic                   in_clk,
  input  logic                   in_reset_n,
  input  logic [NUM_BUTTONS-1:0] in_button,
  output logic [NUM_BUTTONS-1:0] out_level,
  output logic [NUM_BUTTONS-1:0] out_press,
  output logic [NUM_BUTTONS-1:0] out_release,
  output logic [NUM_BUTTONS-1:0] out_repeat,
  output logic [NUM_BUTTONS-1:0] out_event
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1 before clearing.
  localparam int unsigned         DB_W         = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]     DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [25:0]         DELAY_LAST   = 26'(REPEAT_DELAY - 1);
  localparam logic [25:0]         PERIOD_LAST  = 26'(REPEAT_PERIOD - 1);

  logic [NUM_BUTTONS-1:0] sync1;
  logic [NUM_BUTTONS-1:0] sync2;
  logic [NUM_BUTTONS-1:0] pressed_raw;

  // Two-flop synchroniser; resets to the released (high) pin level.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= in_button;
      sync2 <= sync1;
    end
  end

  assign pressed_raw = ~sync2;
  assign out_event   = out_press | out_repeat;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    logic [DB_W-1:0] cnt;
    logic            level;
    logic            press;
    logic            release_pulse;

    // Debounce: level follows the synchronised pin only after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
    always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
        cnt           <= '0;
        level         <= 1'b0;
        press         <= 1'b0;
        release_pulse <= 1'b0;
      end else begin
        press         <= 1'b0;
        release_pulse <= 1'b0;
        if (pressed_raw[i] == level) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          level         <= pressed_raw[i];
          press         <= pressed_raw[i];
          release_pulse <= ~pressed_raw[i];
          cnt           <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign out_level[i]   = level;
    assign out_press[i]   = press;
    assign out_release[i] = release_pulse;

    if (REPEAT_MASK[i]) begin : g_rpt
      typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        PERIOD = 2'd2
      } rpt_state_t;

      rpt_state_t  state;
      logic [25:0] rcnt;
      logic        rpt;
      logic        change;
      logic        rise;
      logic        fall;

      // Same-edge view of the debounced level changing, so the repeat
      // schedule starts in the very cycle the press pulse appears.
      assign change = (pressed_raw[i] != level) && (cnt == DB_LAST);
      assign rise   = change & pressed_raw[i];
      assign fall   = change & ~pressed_raw[i];

      // Auto-repeat: initial delay, then periodic pulses; release aborts.
      always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
          state <= IDLE;
          rcnt  <= '0;
          rpt   <= 1'b0;
        end else begin
          rpt <= 1'b0;
          if (fall) begin
            state <= IDLE;
            rcnt  <= '0;
          end else begin
            case (state)
              IDLE: begin
                rcnt <= '0;
                if (rise) state <= DELAY;
              end
              DELAY: begin
                if (rcnt == DELAY_LAST) begin
                  rpt   <= 1'b1;
                  rcnt  <= '0;
                  state <= PERIOD;
                end else begin
                  rcnt <= rcnt + 26'd1;
                end
              end
              PERIOD: begin
                if (rcnt == PERIOD_LAST) begin
                  rpt  <= 1'b1;
                  rcnt <= '0;
                end else begin
                  rcnt <= rcnt + 26'd1;
                end
              end
              default: begin
                state <= IDLE;
                rcnt  <= '0;
              end
            endcase
          end
        end
      end

      assign out_repeat[i] = rpt;
    end else begin : g_no_rpt
      assign out_repeat[i] = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Scenario tasks plus randomized traffic against a cycle-level
//            behavioural model of the button conditioner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;
  localparam int NB = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam logic [NB-1:0] MASK = 4'b0110;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NB-1:0] btn = 4'hF;
  logic [NB-1:0] level, press, rel, rpt, evt;

  button_conditioner #(
    .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
  ) dut (
    .in_clk(clk), .in_reset_n(rst_n), .in_button(btn),
    .out_level(level), .out_press(press), .out_release(rel),
    .out_repeat(rpt), .out_event(evt)
  );

  always #5 clk = ~clk;

  // Behavioural model: pins reach the logic two edges late; level flips after
  // DB consecutive disagreeing samples; repeats are a function of held time.
  logic [NB-1:0] m_d1, m_d2, m_level, m_press, m_rel, m_rpt;
  int m_run[NB];
  int m_held[NB];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic model_reset();
    m_d1 = '1; m_d2 = '1; m_level = '0; m_press = '0; m_rel = '0; m_rpt = '0;
    for (int i = 0; i < NB; i++) begin m_run[i] = 0; m_held[i] = 0; end
  endtask

  task automatic model_edge();
    logic raw;
    for (int i = 0; i < NB; i++) begin
      raw = ~m_d2[i];
      m_press[i] = 1'b0;
      m_rel[i]   = 1'b0;
      if (raw != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_level[i] = raw;
          m_run[i]   = 0;
          if (raw) m_press[i] = 1'b1; else m_rel[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
      if (m_press[i]) m_held[i] = 0;
      else if (m_level[i]) m_held[i]++;
      m_rpt[i] = MASK[i] && m_level[i] && !m_press[i] && (m_held[i] >= RD)
                 && (((m_held[i] - RD) % RP) == 0);
    end
    m_d2 = m_d1;
    m_d1 = btn;
  endtask

  // Advance one clock; model tracks the DUT; outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({level, press, rel, rpt, evt} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_async got %h required 00000", {level, press, rel, rpt, evt});
    end
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_cmp++;
      if ({level, press, rel, rpt, evt} !== 20'h0) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d got %h required 00000", k, {level, press, rel, rpt, evt});
      end
    end
  endtask

  task automatic test_clean_press();
    int first_p, n_p, first_r;
    first_p = 0; n_p = 0; first_r = 0;
    btn[2] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_cmp++;
      if ({level, press, rel, rpt, evt} !== {m_level, m_press, m_rel, m_rpt, m_press | m_rpt}) begin
        n_fail++;
        $display("FAIL clean_model k=%0d got %h required %h", k, {level, press, rel, rpt, evt},
                 {m_level, m_press, m_rel, m_rpt, m_press | m_rpt});
      end
      if (press[2] && evt[2]) begin n_p++; if (first_p == 0) first_p = k; end
    end
    n_cmp++;
    if (first_p != 6 || n_p != 1 || level[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_press got first=%0d count=%0d level=%b required 6/1/1", first_p, n_p, level[2]);
    end
    btn[2] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_cmp++;
      if ({level, press, rel, rpt, evt} !== {m_level, m_press, m_rel, m_rpt, m_press | m_rpt}) begin
        n_fail++;
        $display("FAIL clean_rel_model k=%0d got %h required %h", k, {level, press, rel, rpt, evt},
                 {m_level, m_press, m_rel, m_rpt, m_press | m_rpt});
      end
      if (rel[2] && first_r == 0) first_r = k;
    end
    n_cmp++;
    if (first_r != 6 || level[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_release got first=%0d level=%b required 6/0", first_r, level[2]);
    end
  endtask

  task automatic test_bounce();
    int first_p, n_p, n_any;
    first_p = 0; n_p = 0; n_any = 0;
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) btn[1] = ~btn[1];
      tick();
      if (press != 0 || rel != 0 || level != 0) n_any++;
    end
    n_cmp++;
    if (n_any != 0) begin
      n_fail++;
      $display("FAIL bounce_quiet got %0d active cycles required 0", n_any);
    end
    btn[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (press[1]) begin n_p++; if (first_p == 0) first_p = k; end
    end
    n_cmp++;
    if (first_p != 6 || n_p != 1) begin
      n_fail++;
      $display("FAIL bounce_press got first=%0d count=%0d required 6/1", first_p, n_p);
    end
    btn[1] = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    n_any = 0;
    btn[3] = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    btn[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (level[3] || press[3] || rel[3]) n_any++;
    end
    n_cmp++;
    if (n_any != 0 || {level, press, rel, rpt} !== {m_level, m_press, m_rel, m_rpt}) begin
      n_fail++;
      $display("FAIL glitch got %0d active cycles, outputs %h required 0, %h", n_any,
               {level, press, rel, rpt}, {m_level, m_press, m_rel, m_rpt});
    end
  endtask

  task automatic test_autorepeat();
    int p, nrep, nrep0, nrel, late;
    int offs[3];
    p = -1; nrep = 0; nrep0 = 0; nrel = 0; late = 0;
    btn[2] = 1'b0; btn[0] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_cmp++;
      if ({level, press, rel, rpt, evt} !== {m_level, m_press, m_rel, m_rpt, m_press | m_rpt}) begin
        n_fail++;
        $display("FAIL repeat_model k=%0d got %h required %h", k, {level, press, rel, rpt, evt},
                 {m_level, m_press, m_rel, m_rpt, m_press | m_rpt});
      end
      if (press[2]) p = k;
      if (rpt[2] && evt[2] && p >= 0) begin
        if (nrep < 3) offs[nrep] = k - p;
        nrep++;
      end
      if (rpt[0]) nrep0++;
    end
    n_cmp++;
    if (nrep < 3 || offs[0] != 10 || offs[1] != 13 || offs[2] != 16) begin
      n_fail++;
      $display("FAIL repeat_times got n=%0d offs=%0d,%0d,%0d required >=3 at 10,13,16",
               nrep, offs[0], offs[1], offs[2]);
    end
    n_cmp++;
    if (nrep0 != 0) begin
      n_fail++;
      $display("FAIL repeat_masked got %0d repeats on button 0 required 0", nrep0);
    end
    btn[2] = 1'b1; btn[0] = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (rel[2]) nrel++;
      if (nrel > 0 && rpt[2]) late++;
    end
    n_cmp++;
    if (nrel != 1 || late != 0) begin
      n_fail++;
      $display("FAIL repeat_release got releases=%0d late_repeats=%0d required 1/0", nrel, late);
    end
  endtask

  task automatic test_reset_mid_hold();
    int p, r;
    p = 0; r = 0;
    btn[1] = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    n_cmp++;
    if (level[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL midhold_level got %b required 1", level[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({level, press, rel, rpt, evt} !== 20'h0) begin
      n_fail++;
      $display("FAIL midhold_async got %h required 00000", {level, press, rel, rpt, evt});
    end
    model_reset();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      n_cmp++;
      if ({level, press, rel, rpt, evt} !== {m_level, m_press, m_rel, m_rpt, m_press | m_rpt}) begin
        n_fail++;
        $display("FAIL midhold_model k=%0d got %h required %h", k, {level, press, rel, rpt, evt},
                 {m_level, m_press, m_rel, m_rpt, m_press | m_rpt});
      end
      if (press[1] && p == 0) p = k;
      if (rpt[1] && r == 0) r = k;
    end
    n_cmp++;
    if (p != 6 || r - p != 10) begin
      n_fail++;
      $display("FAIL midhold_sched got press=%0d repeat_gap=%0d required 6/10", p, r - p);
    end
    btn[1] = 1'b1;
    for (int k = 0; k < 10; k++) tick();
  endtask

  task automatic test_simultaneous();
    int np, nr, diff;
    np = 0; nr = 0; diff = 0;
    btn[1] = 1'b0; btn[2] = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (press[1] !== press[2] || rpt[1] !== rpt[2]) diff++;
      if (press[1] && press[2]) np++;
      if (rpt[1] && rpt[2]) nr++;
    end
    n_cmp++;
    if (diff != 0 || np != 1 || nr < 2) begin
      n_fail++;
      $display("FAIL simultaneous got diff=%0d joint_press=%0d joint_rpt=%0d required 0/1/>=2", diff, np, nr);
    end
    btn = 4'hF;
    for (int k = 0; k < 10; k++) tick();
  endtask

  task automatic test_random();
    int dur[NB];
    int bad;
    bad = 0;
    for (int i = 0; i < NB; i++) dur[i] = $urandom_range(1, 15);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NB; i++) begin
        dur[i]--;
        if (dur[i] <= 0) begin
          btn[i] = ~btn[i];
          dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(1, 8);
        end
      end
      if (k == 1500) begin
        rst_n = 1'b0;
        #1;
      end
      tick();
      if (k == 1502) rst_n = 1'b1;
      n_cmp++;
      if ({level, press, rel, rpt, evt} !== {m_level, m_press, m_rel, m_rpt, m_press | m_rpt}) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random k=%0d got %h required %h", k, {level, press, rel, rpt, evt},
                   {m_level, m_press, m_rel, m_rpt, m_press | m_rpt});
      end
    end
    btn = 4'hF;
    for (int k = 0; k < 10; k++) tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_autorepeat();
    test_reset_mid_hold();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
